// File: rtl/fp_addsub_pkg.sv
// Shared types and constants for the single-precision add/subtract datapath.
package fp_addsub_pkg;

  localparam int MANT_W  = 24;
  localparam int EXP_W   = 8;
  localparam int EXP_MAX = 255;

  typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} norm_state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

endpackage

// File: rtl/add_sub_25bit.sv
// Combinational 25-bit magnitude adder/subtractor for the significand path.
module add_sub_25bit (
  input  logic [24:0] A,
  input  logic [24:0] B,
  input  logic        sub,
  output logic [24:0] S
);

  assign S = sub ? (A - B) : (A + B);

endmodule

// File: rtl/mant_addsub_norm.sv
// Significand add/subtract followed by a one-bit-per-cycle normaliser that
// packs the result into an IEEE-754 single word.
module mant_addsub_norm #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] big_mant,
  input  logic [MANT_W-1:0] small_mant,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic              sign_in,
  input  logic              eff_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              zero_o,
  output logic              ovf_o,
  output logic              unf_o
);
  import fp_addsub_pkg::*;

  localparam int SUM_W = MANT_W + 1;

  norm_state_t       r_state, w_next;
  logic [MANT_W-1:0] r_big, r_small;
  logic [EXP_W-1:0]  r_exp, w_exp_nxt, w_exp_inc;
  logic              r_sign, r_sub;
  logic [SUM_W-1:0]  r_sum, w_sum_nxt, w_add_s;
  fp32_t             r_result, w_res;
  logic              r_zero, r_ovf, r_unf, r_out_valid;
  logic              w_zero, w_ovf, w_unf, w_load;

  add_sub_25bit u_add_sub (
    .A   ({1'b0, r_big}),
    .B   ({1'b0, r_small}),
    .sub (r_sub),
    .S   (w_add_s)
  );

  assign w_exp_inc = r_exp + EXP_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_sum_nxt = r_sum;
    w_exp_nxt = r_exp;
    w_load    = 1'b0;
    w_res     = r_result;
    w_zero    = r_zero;
    w_ovf     = r_ovf;
    w_unf     = r_unf;
    case (r_state)
      IDLE: if (in_valid) w_next = ADD;
      ADD: begin
        w_sum_nxt = w_add_s;
        w_next    = NORM;
      end
      NORM: begin
        if (r_sum == '0) begin
          w_load = 1'b1;
          w_res  = '0;
          w_zero = 1'b1;
          w_ovf  = 1'b0;
          w_unf  = 1'b0;
          w_next = DONE;
        end else if (r_sum[SUM_W-1]) begin
          w_sum_nxt = r_sum >> 1;
          w_exp_nxt = w_exp_inc;
          w_load    = 1'b1;
          w_zero    = 1'b0;
          w_unf     = 1'b0;
          // Carry out: the renormalised fraction is sum[23:1], truncated.
          if (w_exp_inc == EXP_W'(EXP_MAX)) begin
            w_res.sign = r_sign;
            w_res.exp  = 8'hFF;
            w_res.frac = '0;
            w_ovf      = 1'b1;
          end else begin
            w_res.sign = r_sign;
            w_res.exp  = w_exp_inc;
            w_res.frac = r_sum[MANT_W-1:1];
            w_ovf      = 1'b0;
          end
          w_next = DONE;
        end else if (r_sum[MANT_W-1]) begin
          w_load     = 1'b1;
          w_res.sign = r_sign;
          w_res.exp  = r_exp;
          w_res.frac = r_sum[MANT_W-2:0];
          w_zero     = 1'b0;
          w_ovf      = 1'b0;
          w_unf      = 1'b0;
          w_next     = DONE;
        end else if (r_exp == EXP_W'(1)) begin
          w_load     = 1'b1;
          w_res      = '0;
          w_res.sign = r_sign;
          w_zero     = 1'b1;
          w_ovf      = 1'b0;
          w_unf      = 1'b1;
          w_next     = DONE;
        end else begin
          w_sum_nxt = r_sum << 1;
          w_exp_nxt = r_exp - EXP_W'(1);
        end
      end
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_big       <= '0;
      r_small     <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_sub       <= 1'b0;
      r_sum       <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_big   <= big_mant;
        r_small <= small_mant;
        r_exp   <= exp_in;
        r_sign  <= sign_in;
        r_sub   <= eff_sub;
      end else begin
        r_exp <= w_exp_nxt;
      end
      r_sum    <= w_sum_nxt;
      r_result <= w_res;
      r_zero   <= w_zero;
      r_ovf    <= w_ovf;
      r_unf    <= w_unf;
      if (w_load)                             r_out_valid <= 1'b1;
      else if (r_state == DONE && out_ready)  r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero_o    = r_zero;
  assign ovf_o     = r_ovf;
  assign unf_o     = r_unf;

endmodule

// File: tb/tb_mant_addsub_norm.sv
// Directed bench for mant_addsub_norm: latency, packing, flags, backpressure, reset.
module tb_mant_addsub_norm;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] big_mant = '0;
  logic [23:0] small_mant = '0;
  logic [7:0]  exp_in = '0;
  logic        sign_in = 1'b0;
  logic        eff_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero_o, ovf_o, unf_o;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  mant_addsub_norm #(.MANT_W(24), .EXP_W(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .big_mant   (big_mant),
    .small_mant (small_mant),
    .exp_in     (exp_in),
    .sign_in    (sign_in),
    .eff_sub    (eff_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero_o     (zero_o),
    .ovf_o      (ovf_o),
    .unf_o      (unf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drives one operand set and returns just after the accepting edge.
  task automatic start_op(input logic [23:0] b, input logic [23:0] s, input logic [7:0] e,
                          input logic sg, input logic sb);
    big_mant = b; small_mant = s; exp_in = e; sign_in = sg; eff_sub = sb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from acceptance (the accepting edge is edge 1) until out_valid.
  task automatic wait_valid(output int l);
    l = 1;
    while (!out_valid && l < 200) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_out(input string tag, input int l, input int exp_l,
                           input logic [31:0] r, input logic z, input logic o, input logic u);
    chk({tag, "_lat"}, 32'(l), 32'(exp_l));
    chk({tag, "_res"}, result, r);
    chk({tag, "_zero"}, {31'h0, zero_o}, {31'h0, z});
    chk({tag, "_ovf"}, {31'h0, ovf_o}, {31'h0, o});
    chk({tag, "_unf"}, {31'h0, unf_o}, {31'h0, u});
  endtask

  initial begin
    #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1.0 + 1.0
    start_op(24'h800000, 24'h800000, 8'd127, 1'b0, 1'b0);
    wait_valid(lat);
    check_out("add11", lat, 3, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    chk("add11_in_ready", {31'h0, in_ready}, 32'h0);
    drain();
    chk("add11_drain_ov", {31'h0, out_valid}, 32'h0);
    chk("add11_drain_ir", {31'h0, in_ready}, 32'h1);

    // 1.5 - 1.0, one left shift
    start_op(24'hC00000, 24'h800000, 8'd127, 1'b0, 1'b1);
    wait_valid(lat);
    check_out("sub15", lat, 4, 32'h3F00_0000, 1'b0, 1'b0, 1'b0);
    drain();

    // exact cancellation, sign forced positive
    start_op(24'hA00000, 24'hA00000, 8'd100, 1'b1, 1'b1);
    wait_valid(lat);
    check_out("cancel", lat, 3, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    drain();

    // overflow to infinity
    start_op(24'hFFFFFF, 24'hFFFFFF, 8'd254, 1'b0, 1'b0);
    wait_valid(lat);
    check_out("ovf", lat, 3, 32'h7F80_0000, 1'b0, 1'b1, 1'b0);
    drain();

    // backpressure with a competing request held on in_valid
    start_op(24'h800000, 24'h800000, 8'd127, 1'b0, 1'b0);
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'd3);
    big_mant = 24'hC00000; small_mant = 24'h800000; exp_in = 8'd127;
    sign_in = 1'b0; eff_sub = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_res", result, 32'h4000_0000);
      chk("bp_hold_ir", {31'h0, in_ready}, 32'h0);
      chk("bp_hold_ov", {31'h0, out_valid}, 32'h1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_xfer_ir", {31'h0, in_ready}, 32'h1);
    chk("bp_xfer_ov", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_ir", {31'h0, in_ready}, 32'h0);
    wait_valid(lat);
    check_out("bp_second", lat, 4, 32'h3F00_0000, 1'b0, 1'b0, 1'b0);
    drain();

    // reset during the fifth NORM cycle
    start_op(24'h800001, 24'h800000, 8'd127, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_mid_ir", {31'h0, in_ready}, 32'h1);
    chk("rst_mid_ov", {31'h0, out_valid}, 32'h0);
    chk("rst_mid_res", result, 32'h0);
    chk("rst_mid_flags", {29'h0, zero_o, ovf_o, unf_o}, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // rerun: 23 left shifts down to 2^-23
    start_op(24'h800001, 24'h800000, 8'd127, 1'b0, 1'b1);
    wait_valid(lat);
    check_out("tiny", lat, 26, 32'h3400_0000, 1'b0, 1'b0, 1'b0);
    drain();

    // same difference with a small exponent flushes to zero
    start_op(24'h800001, 24'h800000, 8'd10, 1'b0, 1'b1);
    wait_valid(lat);
    check_out("unf", lat, 12, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
